// File: rtl/vend_pkg.sv
// Shared vending definitions: coin codes, coin values and the change-dispenser states.
package vend_pkg;
  localparam logic [2:0] COIN_NONE = 3'd0;
  localparam logic [2:0] COIN_5    = 3'd1;
  localparam logic [2:0] COIN_10   = 3'd2;

  localparam int VAL_5  = 5;
  localparam int VAL_10 = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE,
    S_ERR
  } vend_state_e;
endpackage

// File: rtl/vend_timeout_ctr.sv
// Hopper ack watchdog: counts stalled cycles, expire is high on the last allowed one.
module vend_timeout_ctr #(
  parameter int HOP_TIMEOUT = 16
) (
  input  logic clk,
  input  logic arst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int TW = (HOP_TIMEOUT > 1) ? $clog2(HOP_TIMEOUT) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  assign expire = (cnt_q == TW'(HOP_TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (en && !expire) cnt_d = cnt_q + TW'(1);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/vend_change_dispenser.sv
// Change payout controller: pays a requested amount to the coin hopper, largest coin first.
// Optional statistics counters (coins_paid, faults) are built when VEND_CHANGE_STATS_EN is defined.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int COIN_W      = 3,
  parameter int AMT_W       = 6,
  parameter int MAX_AMT     = 40,
  parameter int HOP_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AMT_W-1:0]  req_amount,
  output logic              coin_valid,
  input  logic              coin_ack,
  output logic [COIN_W-1:0] coin_out,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef VEND_CHANGE_STATS_EN
  ,
  output logic [7:0]        coins_paid,
  output logic [3:0]        faults
`endif
);
  localparam logic [AMT_W-1:0] V5   = AMT_W'(VAL_5);
  localparam logic [AMT_W-1:0] V10  = AMT_W'(VAL_10);
  localparam logic [AMT_W-1:0] VMAX = AMT_W'(MAX_AMT);

  vend_state_e       state_q, state_d;
  logic [AMT_W-1:0]  rem_q, rem_d, coin_amt;
  logic              coin_valid_q, coin_valid_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              accept, xfer, legal, expire;
  logic [COIN_W-1:0] coin_sel;

  assign req_ready  = (state_q == S_IDLE) || (state_q == S_ERR);
  assign accept     = req_valid && req_ready;
  assign xfer       = coin_valid_q && coin_ack;
  assign legal      = (req_amount % V5 == '0) && (req_amount <= VMAX);

  // Selection never exceeds remaining, so the subtract cannot wrap.
  assign coin_sel   = (rem_q >= V10) ? COIN_W'(COIN_10) : COIN_W'(COIN_5);
  assign coin_amt   = (rem_q >= V10) ? V10 : V5;

  assign coin_valid = coin_valid_q;
  assign coin_out   = coin_valid_q ? coin_sel : COIN_W'(COIN_NONE);
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

  vend_timeout_ctr #(.HOP_TIMEOUT(HOP_TIMEOUT)) u_tmo (
    .clk    (clk),
    .arst   (arst),
    .clr    (!coin_valid_q || coin_ack),
    .en     (coin_valid_q && !coin_ack),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE, S_ERR: if (accept) begin
        rem_d = req_amount;
        if (!legal)                state_d = S_ERR;
        else if (req_amount == '0) state_d = S_DONE;
        else                       state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // An ack on the expiry cycle still counts as a transfer.
        if (xfer) begin
          rem_d   = rem_q - coin_amt;
          state_d = (rem_d == '0) ? S_DONE : S_ISSUE;
        end else if (expire) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    coin_valid_d = (state_d == S_ISSUE);
    busy_d       = (state_d == S_ISSUE);
    done_d       = (state_d == S_DONE);
    err_d        = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= S_IDLE;
      rem_q        <= '0;
      coin_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      coin_valid_q <= coin_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

`ifdef VEND_CHANGE_STATS_EN
  logic [7:0] coins_paid_q, coins_paid_d;
  logic [3:0] faults_q, faults_d;
  logic       enter_err;

  // Re-entering ERR from ERR via an illegal request counts as a fresh fault.
  assign enter_err = (state_d == S_ERR) && (accept || (state_q == S_ISSUE));

  always_comb begin
    coins_paid_d = coins_paid_q;
    faults_d     = faults_q;
    if (xfer && coins_paid_q != 8'hff) coins_paid_d = coins_paid_q + 8'd1;
    if (enter_err && faults_q != 4'hf) faults_d     = faults_q + 4'd1;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      coins_paid_q <= '0;
      faults_q     <= '0;
    end else begin
      coins_paid_q <= coins_paid_d;
      faults_q     <= faults_d;
    end
  end

  assign coins_paid = coins_paid_q;
  assign faults     = faults_q;
`endif
endmodule

// File: tb/tb_vend_change_dispenser.sv
// Table-driven bench for vend_change_dispenser with a coin scoreboard queue.
module tb_vend_change_dispenser;
  localparam int COIN_W = 3, AMT_W = 6, MAX_AMT = 40, HOP_TIMEOUT = 16;

  logic              clk, arst, req_valid, req_ready, coin_valid, coin_ack, busy, done, err;
  logic [AMT_W-1:0]  req_amount;
  logic [COIN_W-1:0] coin_out;
`ifdef VEND_CHANGE_STATS_EN
  logic [7:0] coins_paid;
  logic [3:0] faults;
  int exp_paid = 0, exp_faults = 0;
`endif

  vend_change_dispenser #(
    .COIN_W(COIN_W), .AMT_W(AMT_W), .MAX_AMT(MAX_AMT), .HOP_TIMEOUT(HOP_TIMEOUT)
  ) dut (
    .clk(clk), .arst(arst), .req_valid(req_valid), .req_ready(req_ready),
    .req_amount(req_amount), .coin_valid(coin_valid), .coin_ack(coin_ack),
    .coin_out(coin_out), .busy(busy), .done(done), .err(err)
`ifdef VEND_CHANGE_STATS_EN
    , .coins_paid(coins_paid), .faults(faults)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int amount;
    int ack_dly;
    int exp_done;
    int exp_err;
    int exp_busy;
    int exp_cyc;
  } vec_t;

  vec_t tbl[15];
  int   exp_q[$];
  int   n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference coin sequence: largest coin first.
  task automatic push_coins(input int amount);
    int r;
    r = amount;
    while (r > 0) begin
      if (r >= 10) begin exp_q.push_back(2); r -= 10; end
      else         begin exp_q.push_back(1); r -= 5;  end
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int cyc, wait_c, busy_cnt, got_done, got_err;
    v = tbl[idx];
    cyc = 0; wait_c = 0; busy_cnt = 0; got_done = 0; got_err = 0;
    exp_q.delete();
    if (v.amount % 5 == 0 && v.amount <= MAX_AMT) push_coins(v.amount);
    @(negedge clk);
    chk($sformatf("v%0d_req_ready", idx), int'(req_ready), 1);
    req_valid  = 1'b1;
    req_amount = AMT_W'(v.amount);
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      if (done) begin got_done = 1; break; end
      if (err)  begin got_err  = 1; break; end
      coin_ack = 1'b0;
      if (coin_valid) begin
        busy_cnt++;
        chk($sformatf("v%0d_busy", idx), int'(busy), 1);
        if (exp_q.size() == 0) chk($sformatf("v%0d_extra_coin", idx), int'(coin_out), 0);
        else                   chk($sformatf("v%0d_coin", idx), int'(coin_out), exp_q[0]);
        if (wait_c >= v.ack_dly) begin
          coin_ack = 1'b1;
          wait_c   = 0;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
`ifdef VEND_CHANGE_STATS_EN
          exp_paid++;
`endif
        end else begin
          wait_c++;
        end
      end
    end
    coin_ack = 1'b0;
    chk($sformatf("v%0d_done", idx), got_done, v.exp_done);
    chk($sformatf("v%0d_err", idx), got_err, v.exp_err);
    chk($sformatf("v%0d_coin_cycles", idx), busy_cnt, v.exp_busy);
    chk($sformatf("v%0d_latency", idx), cyc, v.exp_cyc);
    if (v.exp_done != 0) chk($sformatf("v%0d_coins_left", idx), exp_q.size(), 0);
    @(negedge clk);
    if (got_done != 0) begin
      chk($sformatf("v%0d_done_pulse", idx), int'(done), 0);
      chk($sformatf("v%0d_idle_ready", idx), int'(req_ready), 1);
    end else begin
      chk($sformatf("v%0d_err_sticky", idx), int'(err), 1);
      chk($sformatf("v%0d_err_novalid", idx), int'(coin_valid), 0);
    end
`ifdef VEND_CHANGE_STATS_EN
    if (v.exp_err != 0) exp_faults++;
    chk($sformatf("v%0d_coins_paid", idx), int'(coins_paid), exp_paid);
    chk($sformatf("v%0d_faults", idx), int'(faults), exp_faults);
`endif
  endtask

  initial begin
    //          amount dly done err busy cyc
    tbl[0]  = '{25,  0,  1, 0, 3,  4};
    tbl[1]  = '{15,  3,  1, 0, 8,  9};
    tbl[2]  = '{7,   0,  0, 1, 0,  1};
    tbl[3]  = '{10,  0,  1, 0, 1,  2};
    tbl[4]  = '{45,  0,  0, 1, 0,  1};
    tbl[5]  = '{50,  0,  0, 1, 0,  1};
    tbl[6]  = '{40,  1,  1, 0, 8,  9};
    tbl[7]  = '{10,  99, 0, 1, 16, 17};
    tbl[8]  = '{10,  15, 1, 0, 16, 17};
    tbl[9]  = '{0,   0,  1, 0, 0,  1};
    tbl[10] = '{35,  0,  1, 0, 4,  5};
    tbl[11] = '{41,  0,  0, 1, 0,  1};
    tbl[12] = '{5,   2,  1, 0, 3,  4};
    tbl[13] = '{30,  0,  1, 0, 3,  4};
    tbl[14] = '{20,  2,  1, 0, 6,  7};

    arst = 1'b1; req_valid = 1'b0; req_amount = '0; coin_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_coin_valid", int'(coin_valid), 0);
    chk("rst_coin_out", int'(coin_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    arst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 1);

    // Async reset in the middle of a 25-unit payout.
    req_valid = 1'b1; req_amount = AMT_W'(25);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_coin_valid", int'(coin_valid), 1);
    chk("mid_coin_out", int'(coin_out), 2);
    #2 arst = 1'b1;
    #1;
    chk("arst_coin_valid", int'(coin_valid), 0);
    chk("arst_coin_out", int'(coin_out), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_err", int'(err), 0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(req_ready), 1);
    chk("post_rst_valid", int'(coin_valid), 0);

    // Ack while idle must be ignored.
    coin_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ack_valid", int'(coin_valid), 0);
      chk("idle_ack_done", int'(done), 0);
    end
    coin_ack = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/vend_change_dispenser.md
Name: vend_change_dispenser

Overview:
Return path of the vending machine: the controller that pays change back to the customer through the coin hopper.
- After a vend, the vending FSM hands this block a change amount.
- The block pays it out with a ready/valid handshake to the coin hopper, largest coin first.
- Coins are emitted on the same 3-bit coin code used on the vending FSM's coin input.
- Sits between the vending FSM and the hopper driver.

Parameters:
COIN_W, 3, coin code width (shared with vending FSM input)
AMT_W, 6, change amount width in units
MAX_AMT, 40, largest legal change request in units
HOP_TIMEOUT, 16, cycles to wait for hopper ack before faulting

Ports:
clk  input  1  system clock, rising edge
arst  input  1  asynchronous reset, active-high
req_valid  input  1  change request present
req_ready  output  1  block can accept a request
req_amount  input  AMT_W  change to pay, in units
coin_valid  output  1  coin_out holds a coin to dispense
coin_ack  input  1  hopper has taken the coin
coin_out  output  COIN_W  coin code: 3'd2 = 10 units, 3'd1 = 5 units, 3'd0 = none
busy  output  1  payout in progress
done  output  1  one-cycle pulse, payout complete
err  output  1  sticky fault: illegal amount or hopper timeout

Behaviour:
- Clock and reset: one clock; arst is asynchronous and active-high.
- Reset values: state IDLE; remaining=0; timer=0; coin_valid=0; coin_out=0; busy=0; done=0; err=0.
- States:
  - IDLE: req_ready=1. Accept on req_valid&&req_ready at a rising edge.
  - ISSUE: coin_valid=1, busy=1.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - ERR: err=1, req_ready=1, coin_valid=0.
- Acceptance (edge N):
  - req_amount is latched into remaining.
  - Illegal if not a multiple of 5 or greater than MAX_AMT. Next state is ERR.
  - req_amount=0 goes to DONE; done pulses in cycle N+1.
  - Otherwise ISSUE; first coin valid in cycle N+1.
- Coin selection is combinational from remaining: 3'd2 if remaining>=10, else 3'd1.
  - coin_out and coin_valid stay stable until acknowledged.
- Handshake: a transfer occurs on coin_valid&&coin_ack at a rising edge.
  - remaining is reduced by 10 or 5 and the timer is cleared.
  - If remaining becomes 0, next state is DONE.
  - Otherwise stay in ISSUE and present the next coin in the following cycle. Back-to-back acks give one coin per cycle.
- coin_ack outside ISSUE is ignored.
- Timeout: timer increments every ISSUE cycle without ack.
  - If timer=HOP_TIMEOUT-1 and there is no ack that cycle, go to ERR and drop coin_valid.
  - remaining is retained for debug, not reported.
  - An ack in the same cycle the timer expires wins: transfer, no error.
- ERR exit: ERR is left only by accepting a new request, which clears err and is processed like an acceptance from IDLE. req_valid is not sampled during ISSUE or DONE.
- Reset mid-payout: immediate return to reset values. The coin in flight is abandoned; the hopper must drop its pending coin when coin_valid falls.
- Width rule: remaining is AMT_W bits and never underflows, because selection guarantees coin value <= remaining.

Optional Feature:
Macro VEND_CHANGE_STATS_EN.
- Defined:
  - Adds output coins_paid (8 bits, saturating at 255): coins transferred since reset.
  - Adds output faults (4 bits, saturating at 15): entries into ERR.
  - Both are cleared only by arst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package vend_pkg, also used by the vending FSM:
  - Coin code constants COIN_NONE=3'd0, COIN_5=3'd1, COIN_10=3'd2.
  - Coin value constants VAL_5=5, VAL_10=10.
  - State enumeration for this block.
- One natural sub-module, vend_timeout_ctr: HOP_TIMEOUT counter with clear and expire outputs.

Test Plan:
- Reset while in ISSUE with remaining=25 → all outputs 0 immediately (asynchronous), state IDLE, req_ready=1 after release.
- req_amount=25, coin_ack tied high → coins 2,2,1 in three consecutive cycles; done pulses the cycle after the third ack; busy high for 3 cycles.
- req_amount=15, coin_ack delayed 3 cycles per coin → coin_out holds 2 for 4 cycles, then holds 1; done after the second ack; no err.
- req_amount=7, then separately req_amount=45 → each goes to ERR one cycle after acceptance; coin_valid never asserts; err stays high until the next legal request is accepted.
- req_amount=10, coin_ack never asserted → err rises HOP_TIMEOUT cycles after coin_valid rose and coin_valid falls. Repeat with the ack landing on the expiry cycle → transfer and done, err=0.
- req_amount=0 → done pulses in the cycle after acceptance, no coins. With VEND_CHANGE_STATS_EN, after the 25-unit scenario coins_paid=3.
